// File: rtl/inst_fetch_queue.sv
// Fetch queue between the I-cache response side of IF and the ID stage.
// Build with IFQ_BYPASS_EN defined to pass a push into an empty queue straight to the pop side in the same cycle.
module inst_fetch_queue #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int EXC_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush_i,
  input  logic                    push_valid_i,
  input  logic [31:0]             push_pc_i,
  input  logic [DATA_WIDTH-1:0]   push_instr_i,
  input  logic [EXC_WIDTH-1:0]    push_exc_i,
  output logic                    push_ready_o,
  output logic                    pop_valid_o,
  input  logic                    pop_ready_i,
  output logic [31:0]             pop_pc_o,
  output logic [DATA_WIDTH-1:0]   pop_instr_o,
  output logic [EXC_WIDTH-1:0]    pop_exc_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 32 + DATA_WIDTH + EXC_WIDTH;

  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]   wp_reg, wp_next;
  logic [PTR_W-1:0]   rp_reg, rp_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               exc_block_reg, exc_block_next;

  logic               empty;
  logic               push_fire;
  logic               bypass;
  logic               wr_en;
  logic               rd_en;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] head_data;

  assign empty        = (count_reg == '0);
  assign push_ready_o = (count_reg != CNT_W'(DEPTH)) & ~exc_block_reg;
  assign push_fire    = push_valid_i & push_ready_o & ~flush_i;

`ifdef IFQ_BYPASS_EN
  assign bypass = empty & push_fire & pop_ready_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry is consumed on the spot, so it never occupies storage.
  assign wr_en   = push_fire & ~bypass;
  assign rd_en   = ~empty & pop_ready_i & ~flush_i;
  assign wr_data = {push_pc_i, push_instr_i, push_exc_i};

  always_comb begin
    wp_next        = wp_reg;
    rp_next        = rp_reg;
    count_next     = count_reg;
    exc_block_next = exc_block_reg;
    if (flush_i) begin
      wp_next        = '0;
      rp_next        = '0;
      count_next     = '0;
      exc_block_next = 1'b0;
    end else begin
      if (wr_en) wp_next = wp_reg + PTR_W'(1);
      if (rd_en) rp_next = rp_reg + PTR_W'(1);
      count_next = count_reg + CNT_W'(wr_en) - CNT_W'(rd_en);
      // Nothing younger than a faulting fetch may enter until the redirect.
      if (push_fire && (push_exc_i != '0)) exc_block_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp_reg        <= '0;
      rp_reg        <= '0;
      count_reg     <= '0;
      exc_block_reg <= 1'b0;
    end else begin
      wp_reg        <= wp_next;
      rp_reg        <= rp_next;
      count_reg     <= count_next;
      exc_block_reg <= exc_block_next;
    end
  end

  // Storage is not reset; contents are only observed while occupied.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (wr_en && (wp_reg == PTR_W'(gi))) mem_reg[gi] <= wr_data;
      end
    end
  endgenerate

  assign head_data = mem_reg[rp_reg];

  always_comb begin
    pop_valid_o = ~empty;
    {pop_pc_o, pop_instr_o, pop_exc_o} = head_data;
    if (bypass) begin
      pop_valid_o = 1'b1;
      {pop_pc_o, pop_instr_o, pop_exc_o} = wr_data;
    end
  end

  assign count_o = count_reg;

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Decoupling FIFO between the instruction-cache response side of the IF stage and the ID stage.
- Buffers {pc, instruction, fetch exception code} entries so decode backpressure does not stall the cache pipeline cycle-for-cycle.
- Its ready output drives the cache-side stall.
- Handles pipeline flush (branch redirect/exception) and blocks fetch after a faulting fetch.

Parameters:
- DEPTH, 8, number of entries; power of 2, ≥2.
- DATA_WIDTH, 32, instruction word width.
- EXC_WIDTH, 5, fetch exception code width; 0 = no exception.

Ports:
- clk  input  1  clock.
- resetn  input  1  synchronous, active-low reset.
- flush_i  input  1  discard all entries and any same-cycle push.
- push_valid_i  input  1  IF offers an entry (cache returned data, i.e. !busy).
- push_pc_i  input  32  PC of offered instruction.
- push_instr_i  input  DATA_WIDTH  instruction word (cache rdata).
- push_exc_i  input  EXC_WIDTH  fetch exception code (AdEL/TLB refill/invalid).
- push_ready_o  output  1  queue can accept; IF/cache stall = ~push_ready_o.
- pop_valid_o  output  1  head entry valid for ID.
- pop_ready_i  input  1  ID consumes head this cycle.
- pop_pc_o  output  32  head PC.
- pop_instr_o  output  DATA_WIDTH  head instruction.
- pop_exc_o  output  EXC_WIDTH  head exception code.
- count_o  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Storage: DEPTH-entry array. Write pointer wp and read pointer rp are $clog2(DEPTH) bits and wrap naturally. Occupancy is held in count (0..DEPTH).
- Push fires = push_valid_i & push_ready_o & ~flush_i. The entry is written at wp and wp increments.
- Pop fires = pop_valid_o & pop_ready_i & ~flush_i. rp increments.
- count next = count + push - pop. A simultaneous push and pop leaves count unchanged.
- push_ready_o = (count != DEPTH) & ~exc_block. It depends only on registered state, so there is no combinational path from pop_ready_i.
  - When full, a same-cycle pop does not enable a push; the push is accepted the next cycle.
- pop_valid_o = (count != 0). pop_pc_o/pop_instr_o/pop_exc_o are a combinational read of entry rp.
- Outputs hold stable while pop_valid_o=1 and pop_ready_i=0.
- Push-to-pop latency is 1 cycle: an entry pushed in cycle N is visible at the head in N+1 if the queue was empty.
- exc_block register:
  - Set when a push fires with push_exc_i != 0.
  - Cleared only by flush_i or reset.
  - While set, push_ready_o=0, so no instructions after a faulting fetch are enqueued.
  - Already-queued entries, including the faulting one, still drain normally.
- flush_i: next cycle wp=rp=0, count=0, exc_block=0. Same-cycle push and pop are both ignored. Flush has priority over every other event.
- Reset (resetn=0 at posedge), including mid-operation:
  - wp=rp=count=0, exc_block=0.
  - Outputs: pop_valid_o=0, push_ready_o=1 (after reset), count_o=0.
  - Storage contents are don't-care; head data outputs are don't-care while pop_valid_o=0.
- No entry is ever duplicated or lost except by flush or reset.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when count==0, push fires, and pop_ready_i=1 in the same cycle, the pushed entry is presented combinationally on pop_* with pop_valid_o=1.
  - The entry is consumed that cycle and is not written. Pointers and count are unchanged. Zero-cycle latency.
  - exc_block still sets if push_exc_i != 0.
- Not defined: no bypass, and the minimum latency is 1 cycle.

Test Plan:
- Fill and drain: 8 consecutive pushes, pop_ready_i=0 -> count_o=8 and push_ready_o=0. Then pop_ready_i=1 for 8 cycles -> PCs returned in order 0x00400000..0x0040001C, then pop_valid_o=0.
- Simultaneous push/pop at count=4 for 20 cycles -> count stays 4, order preserved, wp/rp wrap without loss.
- Full with pop: count=8, push_valid_i=1, pop_ready_i=1 -> push rejected that cycle, count_o=7. Next cycle push accepted, count_o=8.
- Exception block: push PC 0xBFC00100 with push_exc_i=5'h04 -> push_ready_o=0 next cycle and stays 0 with push_valid_i held. Entry pops with pop_exc_o=5'h04. flush_i -> push_ready_o=1, count_o=0.
- Flush with concurrent push and pop at count=3 -> next cycle count_o=0, pop_valid_o=0, pushed entry absent.
- Bypass (IFQ_BYPASS_EN): empty queue, push PC 0x80000000 with pop_ready_i=1 -> same-cycle pop_valid_o=1, pop_pc_o=0x80000000, count_o stays 0. Without the macro -> appears next cycle.
